// File: rtl/dom_ascon_pkg.sv
// Shared constants for the masked Ascon S-box blocks: lookup tables, share type,
// randomness slices, and the ANF coefficients of the inverse S-box derived from its table.
package dom_ascon_pkg;

   localparam int Z_L1_LO = 0;
   localparam int Z_L1_HI = 9;
   localparam int Z_L2_LO = 10;
   localparam int Z_L2_HI = 19;

   typedef struct packed {
      logic [4:0] a;
      logic [4:0] b;
   } share_t;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   localparam logic [4:0] INV [32] = '{
      5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
      5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
      5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
      5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};

   // Moebius transform of one output bit; bit m of the result is the coefficient of
   // the monomial whose variables are the set bits of m.
   function automatic logic [31:0] anf_bit(input int b);
      logic [31:0] t;
      logic [31:0] lo_mask [5];
      lo_mask = '{32'h5555_5555, 32'h3333_3333, 32'h0f0f_0f0f, 32'h00ff_00ff, 32'h0000_ffff};
      t = '0;
      for (int m = 0; m < 32; m++) t[5'(m)] = INV[5'(m)][3'(b)];
      for (int i = 0; i < 5; i++) t = t ^ ((t & lo_mask[i]) << (1 << i));
      return t;
   endfunction

   function automatic int pair_idx(input int m);
      int r;
      r = 0;
      for (int k = 0; k < m; k++) if ($countones(k) == 2) r++;
      return r;
   endfunction

   function automatic int tri_idx(input int m);
      int r;
      r = 0;
      for (int k = 0; k < m; k++) if ($countones(k) == 3) r++;
      return r;
   endfunction

   function automatic int lo_bit(input int m);
      int r;
      r = 0;
      for (int i = 4; i >= 0; i--) if (((m >> i) & 1) != 0) r = i;
      return r;
   endfunction

   function automatic int hi_bit(input int m);
      int r;
      r = 0;
      for (int i = 0; i < 5; i++) if (((m >> i) & 1) != 0) r = i;
      return r;
   endfunction

   localparam logic [31:0] ANF [5] = '{anf_bit(0), anf_bit(1), anf_bit(2), anf_bit(3), anf_bit(4)};

endpackage

// File: rtl/dom_and_en.sv
// One-bit DOM-AND: cross terms are resharded with z and registered before they meet
// the inner-domain term; all registers advance only on en.
module dom_and_en (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic a0,
   input  logic a1,
   input  logic b0,
   input  logic b1,
   input  logic z,
   output logic c0,
   output logic c1
);

   logic inner0, inner1, cross0, cross1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inner0 <= 1'b0;
         inner1 <= 1'b0;
         cross0 <= 1'b0;
         cross1 <= 1'b0;
      end else if (en) begin
         inner0 <= a0 & b0;
         inner1 <= a1 & b1;
         cross0 <= (a0 & b1) ^ z;
         cross1 <= (a1 & b0) ^ z;
      end
   end

   assign c0 = inner0 ^ cross0;
   assign c1 = inner1 ^ cross1;

endmodule

// File: rtl/dom_ascon_sbox_inv.sv
// First-order DOM-masked inverse Ascon S-box, 3-stage pipeline with valid/ready.
// Define DOM_SBOX_INV_FLUSH_EN to zero the shares of every idle stage.
module dom_ascon_sbox_inv
   import dom_ascon_pkg::*;
#(
   parameter int Z_W = 20
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [4:0]     ax,
   input  logic [4:0]     bx,
   input  logic [Z_W-1:0] z,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [4:0]     ay,
   output logic [4:0]     by
);

`ifdef DOM_SBOX_INV_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic           stall, en;
   logic           v1, v2, v3;
   logic           g0, g1, g2;
   share_t         s0, x1, x2;
   logic [Z_W-1:0] z0;
   logic [9:0]     z1;
   logic [9:0]     q1a, q1b, q2a, q2b;
   logic [9:0]     c2a, c2b;
   logic [31:0]    mono_a, mono_b;
   logic [4:0]     ay_d, by_d;

   assign stall     = v3 && !out_ready;
   assign en        = !stall;
   assign in_ready  = en;
   assign out_valid = v3;

   // With flush, each stage's data inputs are zeroed when the valid entering it is low.
   assign g0 = in_valid | !FLUSH;
   assign g1 = v1 | !FLUSH;
   assign g2 = v2 | !FLUSH;

   assign s0.a = ax & {5{g0}};
   assign s0.b = bx & {5{g0}};
   assign z0   = z & {Z_W{g0}};

   for (genvar m = 0; m < 32; m++) begin : g_mono
      if ($countones(m) == 2) begin : g_l1
         localparam int P  = pair_idx(m);
         localparam int LO = lo_bit(m);
         localparam int HI = hi_bit(m);
         dom_and_en u_and (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .a0  (s0.a[LO]),
            .a1  (s0.b[LO]),
            .b0  (s0.a[HI]),
            .b1  (s0.b[HI]),
            .z   (z0[Z_L1_LO+P]),
            .c0  (q1a[P]),
            .c1  (q1b[P])
         );
         assign mono_a[m] = q2a[P];
         assign mono_b[m] = q2b[P];
      end else if ($countones(m) == 3) begin : g_l2
         // x_i x_j x_k = (x_i x_j) from layer 1 times the highest-indexed linear bit
         localparam int T  = tri_idx(m);
         localparam int HI = hi_bit(m);
         localparam int Q  = pair_idx(m ^ (1 << HI));
         dom_and_en u_and (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .a0  (q1a[Q] & g1),
            .a1  (q1b[Q] & g1),
            .b0  (x1.a[HI] & g1),
            .b1  (x1.b[HI] & g1),
            .z   (z1[T] & g1),
            .c0  (c2a[T]),
            .c1  (c2b[T])
         );
         assign mono_a[m] = c2a[T];
         assign mono_b[m] = c2b[T];
      end else if ($countones(m) == 1) begin : g_lin
         localparam int L = lo_bit(m);
         assign mono_a[m] = x2.a[L];
         assign mono_b[m] = x2.b[L];
      end else if (m == 0) begin : g_const
         assign mono_a[m] = 1'b1;
         assign mono_b[m] = 1'b0;
      end else begin : g_none
         assign mono_a[m] = 1'b0;
         assign mono_b[m] = 1'b0;
      end
   end

   // Each share sums only its own domain's monomials; the constant lives in share A.
   always_comb begin
      ay_d = '0;
      by_d = '0;
      for (int b = 0; b < 5; b++) begin
         for (int m = 0; m < 32; m++) begin
            if (ANF[3'(b)][5'(m)]) begin
               ay_d[3'(b)] = ay_d[3'(b)] ^ mono_a[5'(m)];
               by_d[3'(b)] = by_d[3'(b)] ^ mono_b[5'(m)];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         x1  <= '0;
         z1  <= '0;
         x2  <= '0;
         q2a <= '0;
         q2b <= '0;
         ay  <= '0;
         by  <= '0;
      end else if (en) begin
         v1   <= in_valid;
         x1   <= s0;
         z1   <= z0[Z_L2_HI:Z_L2_LO];
         v2   <= v1;
         x2.a <= x1.a & {5{g1}};
         x2.b <= x1.b & {5{g1}};
         q2a  <= q1a & {10{g1}};
         q2b  <= q1b & {10{g1}};
         v3   <= v2;
         ay   <= ay_d & {5{g2}};
         by   <= by_d & {5{g2}};
      end
   end

endmodule

// File: tb/tb_dom_ascon_sbox_inv.sv
// Scoreboard bench for the masked inverse S-box: randomized masks and randomness,
// table/round-trip reference, backpressure and mid-flight reset.
module tb_dom_ascon_sbox_inv;
   import dom_ascon_pkg::*;

   localparam int Z_W = 20;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [4:0]     ax = '0;
   logic [4:0]     bx = '0;
   logic [Z_W-1:0] z = '0;
   logic [Z_W-1:0] z_prev = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [4:0]     ay, by;

   typedef struct {
      logic [4:0] exp;
      int         acc;
      bit         lat;
   } item_t;

   item_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int masked_seen = 0;

   dom_ascon_sbox_inv #(.Z_W(Z_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ax        (ax),
      .bx        (bx),
      .z         (z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ay        (ay),
      .by        (by)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic send(input logic [4:0] sa, input logic [4:0] sbv, input logic [4:0] exp,
                       input bit lat);
      logic [Z_W-1:0] zn;
      int tries;
      item_t it;
      do zn = Z_W'($urandom); while (zn == z_prev);
      @(negedge clk);
      in_valid = 1'b1;
      ax = sa;
      bx = sbv;
      z = zn;
      z_prev = zn;
      tries = 0;
      forever begin
         #2;
         if (in_ready) break;
         tries++;
         if (tries > 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready stuck at 0 for %0d cycles", tries);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      it.exp = exp;
      it.acc = cyc;
      it.lat = lat;
      sb.push_back(it);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin : monitor
      logic [9:0] held_val;
      bit         held;
      item_t      it;
      held = 1'b0;
      held_val = '0;
      forever begin
         @(negedge clk);
         #3;
         if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_shares", 32'({ay, by}), 32'(held_val));
         end
         if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
`ifdef DOM_SBOX_INV_FLUSH_EN
         if (!out_valid) chk("idle_zero", 32'({ay, by}), 32'd0);
`endif
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output ay^by %0h with empty scoreboard", ay ^ by);
            end else begin
               it = sb.pop_front();
               chk("data", 32'(ay ^ by), 32'(it.exp));
               if (it.lat) chk("latency", 32'(cyc - it.acc), 32'd3);
               if (by != 5'd0) masked_seen++;
            end
         end
         held = out_valid && !out_ready;
         held_val = {ay, by};
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [4:0] m, y;
      int perm[32];
      int j, tmp;

      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ay", 32'(ay), 32'd0);
      chk("rst_by", 32'(by), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // directed single transactions
      send(5'h00, 5'h04, 5'h00, 1'b1);
      idle(6);
      send(5'h15, 5'h0a, 5'h02, 1'b1);
      idle(6);

      // every y, 8 random masks each, streamed back-to-back
      for (int yi = 0; yi < 32; yi++) begin
         for (int k = 0; k < 8; k++) begin
            m = 5'($urandom);
            send(5'(yi) ^ m, m, INV[5'(yi)], 1'b1);
         end
      end
      idle(6);

      // backpressure window in the middle of a 6-item stream
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               y = 5'($urandom);
               m = 5'($urandom);
               send(y ^ m, m, INV[y], 1'b0);
            end
         end
         begin
            repeat (3) @(negedge clk);
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      idle(8);

      // round trip through masked forward S-box shares
      for (int i = 0; i < 32; i++) perm[i] = i;
      for (int i = 31; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         tmp = perm[i];
         perm[i] = perm[j];
         perm[j] = tmp;
      end
      for (int i = 0; i < 32; i++) begin
         y = SBOX[5'(perm[i])];
         m = 5'($urandom);
         send(y ^ m, m, 5'(perm[i]), 1'b1);
      end
      idle(6);

      // reset with three items in flight: all dropped, none reappear
      for (int i = 0; i < 3; i++) begin
         y = 5'($urandom);
         m = 5'($urandom);
         send(y ^ m, m, INV[y], 1'b0);
      end
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_ay", 32'(ay), 32'd0);
      chk("midrst_by", 32'(by), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      for (int t = 0; t < 100 && sb.size() > 0; t++) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      chk("shares_masked", 32'(masked_seen > 0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dom_ascon_sbox_inv.md
Name: dom_ascon_sbox_inv

Overview:
- First-order DOM-masked inverse of the 5-bit Ascon S-box; 2-share in, 2-share out.
- The decode direction of the masked forward S-box: for every x and every masking, feeding the forward S-box output shares into this block returns shares of x.
- Used in masked inverse-permutation datapaths and masked S-box self-check.
- Pipelined with valid/ready handshakes; fresh randomness consumed per accepted input.

Parameters:
- Z_W, 20, fresh random bits per transaction: 10 for the quadratic DOM-AND layer, 10 for the cubic layer. Fixed by the algebra; present only for width plumbing.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input shares and z are valid.
- in_ready  out  1  block accepts input this cycle.
- ax  in  5  share A of y; bit 4 = Ascon lane x0, bit 0 = x4.
- bx  in  5  share B of y; same bit order.
- z  in  Z_W  fresh uniform randomness, sampled together with ax/bx.
- out_valid  out  1  output shares valid.
- out_ready  in  1  downstream accepts the output.
- ay  out  5  share A of SBOX_INV(ax^bx).
- by  out  5  share B of SBOX_INV(ax^bx).

Behaviour:
- Function: (ay^by) = INV[(ax^bx)]. INV for indices 0..31 (hex) is: 14 1a 07 0d 00 09 0e 12 0a 06 1d 01 19 15 13 1e 18 16 0b 11 03 05 1c 1f 17 1b 04 08 0f 0c 10 02.
- Algebra: INV has algebraic degree 3.
  - Layer 1: the 10 pairwise DOM-ANDs x_i·x_j, using z[9:0].
  - Layer 2: DOM-ANDs of the required quadratic terms with linear bits, using z[19:10].
  - Implementer derives the ANF; any unused z bits are ignored.
- Share separation: share domains are never combined except inside DOM-AND cross terms, and then only after adding z and registering. No unmasking anywhere.
- Pipeline: 3 stages — layer-1 register, layer-2 register, output register.
  - Latency is 3 cycles from accept (in_valid && in_ready) to out_valid, when there is no stall.
  - Throughput is 1 transaction per cycle.
- Alignment: linear terms, and z[19:10], are carried in registered shares alongside the data so all terms align at their use stage.
- Stall:
  - stall = out_valid && !out_ready.
  - While stalled, all pipeline registers hold and in_ready = 0.
  - Otherwise in_ready = 1 and the whole pipeline advances.
  - No bubbles are collapsed inside the pipe.
- Valid bits: each stage has a valid bit. A stage register loads only when it advances; its contents with a low valid bit are don't-care unless the flush feature below is enabled.
- Output hold: ay/by/out_valid stay stable while out_valid && !out_ready.
- Reset (rst low, asynchronous):
  - All valid bits = 0, so out_valid = 0.
  - ay = by = 0 and all share registers = 0.
  - in_ready = 1 one cycle after rst deasserts.
  - Reset mid-operation drops all in-flight transactions silently.
- Simultaneous events: accept and output-consume in the same cycle is legal and is the steady state.
- Randomness: the z presented with an accepted input is used once. The same z value on consecutive accepted inputs is a bench error, not detected by the block.

Optional Feature:
- Macro DOM_SBOX_INV_FLUSH_EN.
- Defined: every share register whose stage valid is 0 is forced to 0 on the advancing edge, so ay = by = 0 whenever out_valid = 0. This prevents stale shares lingering on idle nets.
- Undefined: idle stages retain old data; ay/by are undefined when out_valid = 0.

Decomposition:
- Shared package dom_ascon_pkg:
  - INV table constant for the bench model.
  - Forward S-box table.
  - Share-pair typedef (a, b; 5 bits).
  - Randomness-slice localparams Z_L1_LO/HI and Z_L2_LO/HI.
- One sub-module, dom_and_en: one-bit DOM-AND with clock-enable on its cross-domain resharing register. It is instantiated for both layers, with enable = !stall.

Test Plan:
- Reset: rst low then high → out_valid = 0, ay = by = 0, in_ready = 1 on the next cycle.
- Single transaction: ax = 0x00, bx = 0x04, random z → 3 cycles later out_valid = 1 and ay^by = 0x00. Then ax = 0x15, bx = 0x0a (y = 0x1f) → ay^by = 0x02.
- Exhaustive streaming: all 32 y values back-to-back, each with 8 random masks, out_ready = 1 → one output per cycle, all matching INV, and ay ≠ ay^by for some samples (i.e. shares are not plain values).
- Backpressure: stream 6 items, drop out_ready for 5 cycles mid-stream → in_ready = 0 during the stall, outputs held stable, no loss or duplication, and order preserved.
- Round trip: random x through the masked forward S-box, then this block → ay^by = x for all 32 x.
- Reset mid-operation: assert rst with 3 items in flight → out_valid = 0 immediately, and no stale item appears after release. With DOM_SBOX_INV_FLUSH_EN, idle ay = by = 0 is checked every cycle.
